platform_spawner: RTL

//  Consumer of the LFSR random horizontal position stream in Doodle Fall.

---
 rtl/doodle_pkg.sv | 28 ++
 rtl/plat_slot_buf.sv | 80 ++++++++
 rtl/platform_spawner.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// Shared Doodle Fall screen constants, spawner FSM states and platform slot layout.
package doodle_pkg;

    localparam int HBP        = 325;
    localparam int VBP        = 31;
    localparam int VFP        = 511;
    localparam int PLAT_WIDTH = 75;
    localparam int HPOS_W     = 10;
    localparam int VPOS_W     = 10;
    localparam int SPAWN_GAP  = 120;
    localparam int STEP_INIT  = 1;
    localparam int STEP_MAX   = 4;
    localparam int STEP_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_RETIRE = 2'd2,
        ST_SPAWN  = 2'd3
    } spawn_state_t;

    typedef struct packed {
        logic              valid;
        logic [HPOS_W-1:0] hpos;
        logic [VPOS_W-1:0] vpos;
    } plat_slot_t;

endpackage

// File: rtl/plat_slot_buf.sv
// Circular buffer of platform slots: scroll-all, retire-oldest and push commands,
// with the slots exposed as flat buses for the renderer and collision logic.
module plat_slot_buf
#(
    parameter int NUM_PLAT   = 4,
    parameter int SPAWN_VPOS = 31,
    localparam int PTR_W     = $clog2(NUM_PLAT)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scroll_en,
    input  logic [3:0]            step,
    input  logic                  retire_head,
    input  logic                  push,
    input  logic [9:0]            push_hpos,
    output logic [PTR_W:0]        count,
    output logic [9:0]            head_vpos,
    output logic                  head_valid,
    output logic [NUM_PLAT-1:0]   plat_valid,
    output logic [10*NUM_PLAT-1:0] plat_hpos,
    output logic [10*NUM_PLAT-1:0] plat_vpos
);
    import doodle_pkg::*;

    plat_slot_t       slot_r [NUM_PLAT];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    // Slot storage, pointers and occupancy; a push in the same frame as a retire leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                slot_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (scroll_en) begin
                for (int i = 0; i < NUM_PLAT; i++) begin
                    if (slot_r[i].valid) begin
                        slot_r[i].vpos <= slot_r[i].vpos + VPOS_W'(step);
                    end
                end
            end
            if (retire_head) begin
                slot_r[rd_ptr_r].valid <= 1'b0;
                rd_ptr_r               <= rd_ptr_r + PTR_W'(1);
            end
            if (push) begin
                slot_r[wr_ptr_r] <= '{valid: 1'b1, hpos: push_hpos, vpos: VPOS_W'(SPAWN_VPOS)};
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            case ({push, retire_head})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Flatten slots onto the read buses
    always_comb begin
        plat_valid = '0;
        plat_hpos  = '0;
        plat_vpos  = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            plat_valid[i]         = slot_r[i].valid;
            plat_hpos[10*i +: 10] = slot_r[i].hpos;
            plat_vpos[10*i +: 10] = slot_r[i].vpos;
        end
    end

    assign count      = count_r;
    assign head_vpos  = slot_r[rd_ptr_r].vpos;
    assign head_valid = slot_r[rd_ptr_r].valid;

endmodule

// File: rtl/platform_spawner.sv
// Per-frame platform scroll / retire / spawn sequencer for Doodle Fall.
// Optional feature: define PLAT_SPEEDUP_EN to raise the scroll step every 16 spawns.
module platform_spawner
#(
    parameter int NUM_PLAT  = 4,
    parameter int VBP       = 31,
    parameter int VFP       = 511,
    parameter int SPAWN_GAP = 120,
    parameter int STEP_INIT = 1,
    parameter int STEP_MAX  = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   pause,
    input  logic [9:0]             rand_hpos,
    output logic [NUM_PLAT-1:0]    plat_valid,
    output logic [10*NUM_PLAT-1:0] plat_hpos,
    output logic [10*NUM_PLAT-1:0] plat_vpos,
    output logic                   spawn_pulse,
    output logic                   busy,
    output logic                   overflow,
    output logic                   missed_tick
);
    import doodle_pkg::*;

    localparam int PTR_W = $clog2(NUM_PLAT);
    localparam int GAP_W = $clog2(SPAWN_GAP + STEP_MAX + 1);

    spawn_state_t      state_r, state_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_sat_s;
    logic [GAP_W:0]    gap_sum_s;
    logic [STEP_W-1:0] step_r;
    logic [PTR_W:0]    count_s;
    logic [9:0]        head_vpos_s;
    logic              head_valid_s;
    logic              scroll_s, retire_s, push_s, drop_s, spawn_due_s;
    logic              spawn_pulse_r, busy_r, overflow_r, missed_tick_r;

    plat_slot_buf #(
        .NUM_PLAT   (NUM_PLAT),
        .SPAWN_VPOS (VBP)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .scroll_en   (scroll_s),
        .step        (step_r),
        .retire_head (retire_s),
        .push        (push_s),
        .push_hpos   (rand_hpos),
        .count       (count_s),
        .head_vpos   (head_vpos_s),
        .head_valid  (head_valid_s),
        .plat_valid  (plat_valid),
        .plat_hpos   (plat_hpos),
        .plat_vpos   (plat_vpos)
    );

    // Next state and the per-state buffer commands
    always_comb begin
        state_s     = state_r;
        scroll_s    = 1'b0;
        retire_s    = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        spawn_due_s = (gap_cnt_r >= GAP_W'(SPAWN_GAP));
        case (state_r)
            ST_IDLE: begin
                if (frame_tick && !pause) begin
                    state_s = ST_SCROLL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCROLL: begin
                scroll_s = 1'b1;
                state_s  = ST_RETIRE;
            end
            ST_RETIRE: begin
                state_s = ST_SPAWN;
                if (head_valid_s && (head_vpos_s >= 10'(VFP))) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end
            ST_SPAWN: begin
                state_s = ST_IDLE;
                if (spawn_due_s && (count_s < (PTR_W+1)'(NUM_PLAT))) begin
                    push_s = 1'b1;
                end else if (spawn_due_s) begin
                    drop_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Gap counter advance, saturating so a long idle stretch still spawns only once
    always_comb begin
        gap_sum_s = {1'b0, gap_cnt_r} + (GAP_W+1)'(step_r);
        if (gap_sum_s > (GAP_W+1)'(SPAWN_GAP)) begin
            gap_sat_s = GAP_W'(SPAWN_GAP);
        end else begin
            gap_sat_s = gap_sum_s[GAP_W-1:0];
        end
    end

    // FSM register, gap counter, pulse/busy outputs and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= GAP_W'(SPAWN_GAP);
            spawn_pulse_r <= 1'b0;
            busy_r        <= 1'b0;
            overflow_r    <= 1'b0;
            missed_tick_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            spawn_pulse_r <= push_s;
            busy_r        <= (state_s != ST_IDLE);
            if (scroll_s) begin
                gap_cnt_r <= gap_sat_s;
            end else if (push_s || drop_s) begin
                gap_cnt_r <= '0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (frame_tick && (state_r != ST_IDLE)) begin
                missed_tick_r <= 1'b1;
            end
        end
    end

`ifdef PLAT_SPEEDUP_EN
    logic [3:0] spawn_cnt_r;

    // Every 16th successful spawn bumps the scroll step up to the ceiling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt_r <= 4'd0;
            step_r      <= STEP_W'(STEP_INIT);
        end else if (push_s) begin
            spawn_cnt_r <= spawn_cnt_r + 4'd1;
            if ((spawn_cnt_r == 4'd15) && (step_r < STEP_W'(STEP_MAX))) begin
                step_r <= step_r + STEP_W'(1);
            end
        end
    end
`else
    // Fixed scroll speed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= STEP_W'(STEP_INIT);
        end else begin
            step_r <= STEP_W'(STEP_INIT);
        end
    end
`endif

    assign spawn_pulse = spawn_pulse_r;
    assign busy        = busy_r;
    assign overflow    = overflow_r;
    assign missed_tick = missed_tick_r;

endmodule
